fxu_exec_unit: RTL and testbench
================================

Name: fxu_exec_unit

Overview:
- Single-issue fixed-point execution unit; sits between a reservation station and the common data bus (CDB) in the out-of-order core.
- Accepts one fully-resolved operation per cycle: opcode, ROB index, two 16-bit operands, 8-bit immediate.
- Broadcasts the result tagged with its ROB index on its CDB lane exactly one cycle later.

Parameters:
- DATA_W, 16, operand/result width.
- ROB_IDX_W, 4, ROB index width (16-entry ROB).
- IMM_W, 8, immediate width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  issue strobe from reservation station.
- in_opcode  input  4  operation select.
- in_rob_idx  input  ROB_IDX_W  destination ROB entry.
- in_op_a  input  DATA_W  operand A (ra value).
- in_op_b  input  DATA_W  operand B (rb value).
- in_imm  input  IMM_W  instruction immediate.
- cdb_valid  output  1  result broadcast valid.
- cdb_rob_idx  output  ROB_IDX_W  ROB index of broadcast result.
- cdb_value  output  DATA_W  result value.
- illegal_op  output  1  one-cycle pulse: issued opcode not an FXU op.

Behaviour:
- Clock/reset: one clock clk; rst is synchronous, active-high. While rst is high at a rising edge, all outputs are cleared to 0 on that edge: cdb_valid=0, cdb_rob_idx=0, cdb_value=0, illegal_op=0.
- rst has priority over in_valid. An op issued in the same cycle as rst is discarded and never broadcast.
- Latency: fixed 1 cycle, registered outputs, no combinational path from inputs to outputs.
- Throughput: 1 op/cycle. No stall or backpressure: the unit is always ready, and the reservation station may issue every cycle.
- in_valid=0 at an edge: cdb_valid and illegal_op go 0. cdb_rob_idx and cdb_value hold their previous values, which are don't-care for consumers.
- Opcode map (sext = sign-extend imm to DATA_W; arithmetic wraps modulo 2^16):
  - 0 ADD: a+b
  - 1 SUB: a-b
  - 2 AND: a&b
  - 3 OR: a|b
  - 4 XOR: a^b
  - 5 SHL: a << b[3:0]
  - 6 SHR: logical a >> b[3:0]
  - 7 SRA: arithmetic a >>> b[3:0]
  - 8 MOVL: sext(imm)
  - 9 MOVH: {imm, a[7:0]}
  - 10 ADDI: a+sext(imm)
  - 11 SLT: signed a<b → 1 else 0
  - 12 SLTU: unsigned a<b → 1 else 0
- Shift amounts use only b[3:0]; upper bits of b are ignored.
- Opcodes 13–15 (load/store/branch class) are illegal here:
  - no broadcast: cdb_valid=0 next cycle;
  - illegal_op=1 for exactly one cycle;
  - cdb_rob_idx/cdb_value are not updated.
- Legal op with in_valid=1 at edge N: at edge N, cdb_valid=1, cdb_rob_idx=in_rob_idx, cdb_value=result. These values are visible through cycle N+1.
- Back-to-back issues produce back-to-back broadcasts, each with its own index. There is no internal ordering state.
- No flags, no carry-out, no exceptions on overflow.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, opcode 0 → cdb_valid=0, cdb_rob_idx=0, cdb_value=0, illegal_op=0 throughout. After release with in_valid=0 → outputs remain 0.
- ADD wrap: in_valid=1, op=0, a=16'hFFFF, b=16'h0002, idx=5 → next cycle cdb_valid=1, idx=5, value=16'h0001. SUB 3-5 → 16'hFFFE.
- Immediate ops: MOVL imm=8'h80 → 16'hFF80; MOVH imm=8'hAB, a=16'h1234 → 16'hAB34; ADDI a=16'h0010, imm=8'hFF → 16'h000F.
- Shifts/compares: SRA a=16'h8000, b=16'h0014 (amount 4) → 16'hF800; SHR same → 16'h0800; SLT a=16'hFFFF, b=1 → 1; SLTU same → 0.
- Pipelining: issue ADD idx=1, XOR idx=2, AND idx=3 on consecutive cycles → three consecutive cdb_valid=1 cycles with idx 1,2,3 and correct values; idle cycle → cdb_valid=0.
- Illegal/reset interaction:
  - opcode 14, idx=7 → next cycle cdb_valid=0, illegal_op=1 for one cycle, cdb_rob_idx unchanged.
  - issue ADD with rst=1 in same cycle → no broadcast.

Source files
------------

// File: rtl/fxu_exec_unit.sv
// Single-issue fixed-point execution unit: one resolved op per cycle, result
// broadcast on the CDB lane one cycle later, tagged with its ROB index.
module fxu_exec_unit #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ROB_IDX_W = 4,
    parameter int unsigned IMM_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [3:0]           in_opcode,
    input  logic [ROB_IDX_W-1:0] in_rob_idx,
    input  logic [DATA_W-1:0]    in_op_a,
    input  logic [DATA_W-1:0]    in_op_b,
    input  logic [IMM_W-1:0]     in_imm,
    output logic                 cdb_valid,
    output logic [ROB_IDX_W-1:0] cdb_rob_idx,
    output logic [DATA_W-1:0]    cdb_value,
    output logic                 illegal_op
);

    localparam int unsigned SHAMT_W = $clog2(DATA_W);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SHL  = 4'd5,
        OP_SHR  = 4'd6,
        OP_SRA  = 4'd7,
        OP_MOVL = 4'd8,
        OP_MOVH = 4'd9,
        OP_ADDI = 4'd10,
        OP_SLT  = 4'd11,
        OP_SLTU = 4'd12
    } fxu_op_e;

    logic                 cdb_valid_q,   cdb_valid_d;
    logic [ROB_IDX_W-1:0] cdb_rob_idx_q, cdb_rob_idx_d;
    logic [DATA_W-1:0]    cdb_value_q,   cdb_value_d;
    logic                 illegal_op_q,  illegal_op_d;

    logic [DATA_W-1:0]    imm_sext;
    logic [SHAMT_W-1:0]   shamt;
    logic [DATA_W-1:0]    result;
    logic                 op_legal;

    always_comb begin
        imm_sext = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
        shamt    = in_op_b[SHAMT_W-1:0];
        op_legal = (in_opcode <= OP_SLTU);
    end

    always_comb begin
        result = '0;
        case (fxu_op_e'(in_opcode))
            OP_ADD:  result = in_op_a + in_op_b;
            OP_SUB:  result = in_op_a - in_op_b;
            OP_AND:  result = in_op_a & in_op_b;
            OP_OR:   result = in_op_a | in_op_b;
            OP_XOR:  result = in_op_a ^ in_op_b;
            OP_SHL:  result = in_op_a << shamt;
            OP_SHR:  result = in_op_a >> shamt;
            OP_SRA:  result = DATA_W'($signed(in_op_a) >>> shamt);
            OP_MOVL: result = imm_sext;
            OP_MOVH: result = {in_imm, in_op_a[DATA_W-IMM_W-1:0]};
            OP_ADDI: result = in_op_a + imm_sext;
            OP_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(in_op_a) < $signed(in_op_b))};
            OP_SLTU: result = {{(DATA_W-1){1'b0}}, (in_op_a < in_op_b)};
            default: result = '0;
        endcase
    end

    // Tag and value only move on a legal issue so an illegal op leaves the
    // last broadcast visible on the lane.
    always_comb begin
        cdb_valid_d   = in_valid & op_legal;
        illegal_op_d  = in_valid & ~op_legal;
        cdb_rob_idx_d = cdb_rob_idx_q;
        cdb_value_d   = cdb_value_q;
        if (in_valid && op_legal) begin
            cdb_rob_idx_d = in_rob_idx;
            cdb_value_d   = result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid_q   <= 1'b0;
            cdb_rob_idx_q <= '0;
            cdb_value_q   <= '0;
            illegal_op_q  <= 1'b0;
        end else begin
            cdb_valid_q   <= cdb_valid_d;
            cdb_rob_idx_q <= cdb_rob_idx_d;
            cdb_value_q   <= cdb_value_d;
            illegal_op_q  <= illegal_op_d;
        end
    end

    assign cdb_valid   = cdb_valid_q;
    assign cdb_rob_idx = cdb_rob_idx_q;
    assign cdb_value   = cdb_value_q;
    assign illegal_op  = illegal_op_q;

endmodule

// File: tb/tb_fxu_exec_unit.sv
// Directed bench for fxu_exec_unit; observed word is {cdb_valid, illegal_op, cdb_rob_idx, cdb_value}.
module tb_fxu_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  in_opcode;
    logic [3:0]  in_rob_idx;
    logic [15:0] in_op_a;
    logic [15:0] in_op_b;
    logic [7:0]  in_imm;
    logic        cdb_valid;
    logic [3:0]  cdb_rob_idx;
    logic [15:0] cdb_value;
    logic        illegal_op;

    int tests_run = 0;
    int tests_failed = 0;

    logic [21:0] obs;
    logic [21:0] exp_w;
    assign obs = {cdb_valid, illegal_op, cdb_rob_idx, cdb_value};

    fxu_exec_unit #(.DATA_W(16), .ROB_IDX_W(4), .IMM_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_opcode  (in_opcode),
        .in_rob_idx (in_rob_idx),
        .in_op_a    (in_op_a),
        .in_op_b    (in_op_b),
        .in_imm     (in_imm),
        .cdb_valid  (cdb_valid),
        .cdb_rob_idx(cdb_rob_idx),
        .cdb_value  (cdb_value),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and return just after the capturing edge.
    task automatic drive(input logic r, input logic v, input logic [3:0] op, input logic [3:0] idx,
                         input logic [15:0] a, input logic [15:0] b, input logic [7:0] imm);
        @(negedge clk);
        rst = r; in_valid = v; in_opcode = op; in_rob_idx = idx;
        in_op_a = a; in_op_b = b; in_imm = imm;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 4'd0, 4'd9, 16'h0001, 16'h0001, 8'h00);
            exp_w = {1'b0, 1'b0, 4'd0, 16'h0000};
            tests_run++;
            if (obs !== exp_w) begin
                tests_failed++;
                $display("FAIL reset_hold[%0d]: got %h expected %h", i, obs, exp_w);
            end
        end
        drive(1'b0, 1'b0, 4'd0, 4'd9, 16'h0001, 16'h0001, 8'h00);
        exp_w = {1'b0, 1'b0, 4'd0, 16'h0000};
        tests_run++;
        if (obs !== exp_w) begin
            tests_failed++;
            $display("FAIL reset_release_idle: got %h expected %h", obs, exp_w);
        end
    endtask

    task automatic test_arith();
        drive(1'b0, 1'b1, 4'd0, 4'd5, 16'hFFFF, 16'h0002, 8'h00);
        exp_w = {1'b1, 1'b0, 4'd5, 16'h0001};
        tests_run++;
        if (obs !== exp_w) begin
            tests_failed++;
            $display("FAIL add_wrap: got %h expected %h", obs, exp_w);
        end
        drive(1'b0, 1'b1, 4'd1, 4'd6, 16'h0003, 16'h0005, 8'h00);
        exp_w = {1'b1, 1'b0, 4'd6, 16'hFFFE};
        tests_run++;
        if (obs !== exp_w) begin
            tests_failed++;
            $display("FAIL sub_wrap: got %h expected %h", obs, exp_w);
        end
        drive(1'b0, 1'b1, 4'd3, 4'd4, 16'hA000, 16'h000A, 8'h00);
        exp_w = {1'b1, 1'b0, 4'd4, 16'hA00A};
        tests_run++;
        if (obs !== exp_w) begin
            tests_failed++;
            $display("FAIL or: got %h expected %h", obs, exp_w);
        end
    endtask

    task automatic test_imm();
        drive(1'b0, 1'b1, 4'd8, 4'd10, 16'h5555, 16'h0000, 8'h80);
        exp_w = {1'b1, 1'b0, 4'd10, 16'hFF80};
        tests_run++;
        if (obs !== exp_w) begin
            tests_failed++;
            $display("FAIL movl_sext: got %h expected %h", obs, exp_w);
        end
        drive(1'b0, 1'b1, 4'd9, 4'd11, 16'h1234, 16'h0000, 8'hAB);
        exp_w = {1'b1, 1'b0, 4'd11, 16'hAB34};
        tests_run++;
        if (obs !== exp_w) begin
            tests_failed++;
            $display("FAIL movh: got %h expected %h", obs, exp_w);
        end
        drive(1'b0, 1'b1, 4'd10, 4'd12, 16'h0010, 16'h0000, 8'hFF);
        exp_w = {1'b1, 1'b0, 4'd12, 16'h000F};
        tests_run++;
        if (obs !== exp_w) begin
            tests_failed++;
            $display("FAIL addi_neg: got %h expected %h", obs, exp_w);
        end
    endtask

    task automatic test_shift_cmp();
        drive(1'b0, 1'b1, 4'd7, 4'd13, 16'h8000, 16'h0014, 8'h00);
        exp_w = {1'b1, 1'b0, 4'd13, 16'hF800};
        tests_run++;
        if (obs !== exp_w) begin
            tests_failed++;
            $display("FAIL sra: got %h expected %h", obs, exp_w);
        end
        drive(1'b0, 1'b1, 4'd6, 4'd14, 16'h8000, 16'h0014, 8'h00);
        exp_w = {1'b1, 1'b0, 4'd14, 16'h0800};
        tests_run++;
        if (obs !== exp_w) begin
            tests_failed++;
            $display("FAIL shr: got %h expected %h", obs, exp_w);
        end
        drive(1'b0, 1'b1, 4'd5, 4'd15, 16'h0001, 16'hFFF3, 8'h00);
        exp_w = {1'b1, 1'b0, 4'd15, 16'h0008};
        tests_run++;
        if (obs !== exp_w) begin
            tests_failed++;
            $display("FAIL shl_masked: got %h expected %h", obs, exp_w);
        end
        drive(1'b0, 1'b1, 4'd11, 4'd2, 16'hFFFF, 16'h0001, 8'h00);
        exp_w = {1'b1, 1'b0, 4'd2, 16'h0001};
        tests_run++;
        if (obs !== exp_w) begin
            tests_failed++;
            $display("FAIL slt: got %h expected %h", obs, exp_w);
        end
        drive(1'b0, 1'b1, 4'd12, 4'd3, 16'hFFFF, 16'h0001, 8'h00);
        exp_w = {1'b1, 1'b0, 4'd3, 16'h0000};
        tests_run++;
        if (obs !== exp_w) begin
            tests_failed++;
            $display("FAIL sltu: got %h expected %h", obs, exp_w);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b1, 4'd0, 4'd1, 16'h0010, 16'h0020, 8'h00);
        exp_w = {1'b1, 1'b0, 4'd1, 16'h0030};
        tests_run++;
        if (obs !== exp_w) begin
            tests_failed++;
            $display("FAIL b2b_add: got %h expected %h", obs, exp_w);
        end
        drive(1'b0, 1'b1, 4'd4, 4'd2, 16'hFF00, 16'h0FF0, 8'h00);
        exp_w = {1'b1, 1'b0, 4'd2, 16'hF0F0};
        tests_run++;
        if (obs !== exp_w) begin
            tests_failed++;
            $display("FAIL b2b_xor: got %h expected %h", obs, exp_w);
        end
        drive(1'b0, 1'b1, 4'd2, 4'd3, 16'hF0F0, 16'h0FF0, 8'h00);
        exp_w = {1'b1, 1'b0, 4'd3, 16'h00F0};
        tests_run++;
        if (obs !== exp_w) begin
            tests_failed++;
            $display("FAIL b2b_and: got %h expected %h", obs, exp_w);
        end
        drive(1'b0, 1'b0, 4'd0, 4'd9, 16'h1111, 16'h2222, 8'h00);
        exp_w = {1'b0, 1'b0, 4'd3, 16'h00F0};
        tests_run++;
        if (obs !== exp_w) begin
            tests_failed++;
            $display("FAIL b2b_idle_hold: got %h expected %h", obs, exp_w);
        end
    endtask

    task automatic test_illegal();
        drive(1'b0, 1'b1, 4'd14, 4'd7, 16'h1234, 16'h5678, 8'h00);
        exp_w = {1'b0, 1'b1, 4'd3, 16'h00F0};
        tests_run++;
        if (obs !== exp_w) begin
            tests_failed++;
            $display("FAIL illegal_pulse: got %h expected %h", obs, exp_w);
        end
        drive(1'b0, 1'b0, 4'd0, 4'd0, 16'h0000, 16'h0000, 8'h00);
        exp_w = {1'b0, 1'b0, 4'd3, 16'h00F0};
        tests_run++;
        if (obs !== exp_w) begin
            tests_failed++;
            $display("FAIL illegal_one_cycle: got %h expected %h", obs, exp_w);
        end
        drive(1'b0, 1'b1, 4'd13, 4'd8, 16'h0001, 16'h0001, 8'h00);
        exp_w = {1'b0, 1'b1, 4'd3, 16'h00F0};
        tests_run++;
        if (obs !== exp_w) begin
            tests_failed++;
            $display("FAIL illegal_op13: got %h expected %h", obs, exp_w);
        end
    endtask

    task automatic test_reset_issue();
        drive(1'b0, 1'b1, 4'd0, 4'd9, 16'h0100, 16'h0200, 8'h00);
        exp_w = {1'b1, 1'b0, 4'd9, 16'h0300};
        tests_run++;
        if (obs !== exp_w) begin
            tests_failed++;
            $display("FAIL pre_reset_add: got %h expected %h", obs, exp_w);
        end
        drive(1'b1, 1'b1, 4'd0, 4'd8, 16'h0004, 16'h0004, 8'h00);
        exp_w = {1'b0, 1'b0, 4'd0, 16'h0000};
        tests_run++;
        if (obs !== exp_w) begin
            tests_failed++;
            $display("FAIL reset_drops_issue: got %h expected %h", obs, exp_w);
        end
        drive(1'b0, 1'b0, 4'd0, 4'd8, 16'h0004, 16'h0004, 8'h00);
        exp_w = {1'b0, 1'b0, 4'd0, 16'h0000};
        tests_run++;
        if (obs !== exp_w) begin
            tests_failed++;
            $display("FAIL reset_no_late_bcast: got %h expected %h", obs, exp_w);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_opcode = '0; in_rob_idx = '0;
        in_op_a = '0; in_op_b = '0; in_imm = '0;
        test_reset();
        test_arith();
        test_imm();
        test_shift_cmp();
        test_back_to_back();
        test_illegal();
        test_reset_issue();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
